instr_fetch: RTL

//  Fetch stage feeding decode_instr. Holds the PC, drives the instruction-memory address,
//  and registers {instr, pc_plus4, valid} into the IF/ID pipeline register.

---
 rtl/mips_pkg.sv | 21 ++
 rtl/if_id_reg.sv | 27 ++
 rtl/instr_fetch.sv | 85 ++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: NOP encoding, reset PC default, opcodes and the IF/ID record.
package mips_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic        valid;
  } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: sync reset, then flush (to a NOP bubble), then load, else hold.
module if_id_reg
  import mips_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   load_i,
  input  logic   flush_i,
  input  if_id_t d_i,
  output if_id_t q_o
);

  if_id_t entry_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      entry_q <= '{instr: NOP_INSTR, pc_plus4: 32'h0, valid: 1'b0};
    end else if (flush_i) begin
      entry_q <= '{instr: NOP_INSTR, pc_plus4: 32'h0, valid: 1'b0};
    end else if (load_i) begin
      entry_q <= d_i;
    end
  end

  assign q_o = entry_q;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC register, next-PC mux (rst > branch > jump > stall > pc+4) and IF/ID feed.
// Optional BRANCH_DELAY_SLOT_EN: a redirect loads the fetched word into IF/ID instead of flushing.
module instr_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          IMEM_AW  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [31:0]        branch_target,
  input  logic               jump,
  input  logic [25:0]        instr_index,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic [31:0]        pc,
  output logic [31:0]        id_instr,
  output logic [31:0]        id_pc_plus4,
  output logic               id_valid
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_plus4;
  logic [31:0] jump_target;
  logic        redirect;
  logic        ifid_load;
  logic        ifid_flush;
  if_id_t      ifid_d, ifid_q;

  // Byte-offset bits of the branch target are dropped by design.
  logic unused_target_bits;
  assign unused_target_bits = ^branch_target[1:0];

  assign pc_plus4    = pc_q + 32'd4;
  assign jump_target = {ifid_q.pc_plus4[31:28], instr_index, 2'b00};
  assign redirect    = branch_taken | jump;

  always_comb begin
    pc_d = pc_q;
    if (branch_taken) begin
      pc_d = {branch_target[31:2], 2'b00};
    end else if (jump) begin
      pc_d = jump_target;
    end else if (!stall) begin
      pc_d = pc_plus4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign ifid_d = '{instr: imem_rdata, pc_plus4: pc_plus4, valid: 1'b1};

`ifdef BRANCH_DELAY_SLOT_EN
  // The word after a redirecting instruction is kept as its delay slot.
  assign ifid_flush = 1'b0;
  assign ifid_load  = redirect | ~stall;
`else
  assign ifid_flush = redirect;
  assign ifid_load  = ~stall;
`endif

  if_id_reg u_if_id_reg (
    .clk     (clk),
    .rst     (rst),
    .load_i  (ifid_load),
    .flush_i (ifid_flush),
    .d_i     (ifid_d),
    .q_o     (ifid_q)
  );

  assign imem_addr   = pc_q[IMEM_AW+1:2];
  assign pc          = pc_q;
  assign id_instr    = ifid_q.instr;
  assign id_pc_plus4 = ifid_q.pc_plus4;
  assign id_valid    = ifid_q.valid;

endmodule
